dip_word_loader: RTL and testbench
==================================

Name: dip_word_loader

Overview:
- Clocked, parametrised successor to the DIP-switch nibble loader feeding the Manchester encoder datapath.
- Assembles an N-segment word from a SW_WIDTH-bit DIP switch, one segment per debounced press of the shift button.
- Presents each completed word on a valid/ready handshake toward the encoder's transmit register.
- Adds metastability sync, debounce, selectable fill order, overflow flag and synchronous clear.

Parameters:
SW_WIDTH, 4, bits per DIP-switch segment
NUM_SEGS, 2, segments per word; word width W = SW_WIDTH*NUM_SEGS (NUM_SEGS >= 2)
DEBOUNCE_CYCLES, 4, clk cycles the synchronised shift_in must be stable before its level is accepted (>= 1)
MSB_FIRST, 0, 0: first press fills bits [SW_WIDTH-1:0]; 1: first press fills the top segment

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  active-low enable; presses ignored while high
dip_switch  in  SW_WIDTH  switch value; sampled only on an accepted press
shift_in  in  1  raw push-button, asynchronous to clk
clear  in  1  synchronous clear of fill progress
word_ready  in  1  downstream accepts out_word
out_word  out  W  last completed word
word_valid  out  1  out_word holds an unaccepted word
stage_word  out  W  partially assembled word (live preview)
seg_index  out  clog2(NUM_SEGS)  next segment to fill
overflow  out  1  sticky: a word completed while the previous one was still pending

Behaviour:
- Reset (rst_n low, async): all outputs and internal registers = 0; debounced level = 0.
- Input path: shift_in -> 2-FF synchroniser -> debounce counter.
  - Debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- step = one-cycle pulse on each 0->1 transition of the debounced level.
- Latency from a clean shift_in rise to step is 2 + DEBOUNCE_CYCLES cycles.
- Accepted press = step AND cs low. When cs is high, step is discarded and nothing changes.
- On an accepted press:
  - dip_switch is written into stage_word segment k.
  - k = seg_index when MSB_FIRST = 0; k = NUM_SEGS-1-seg_index when MSB_FIRST = 1.
  - seg_index then increments.
- Completion: a press with seg_index = NUM_SEGS-1.
  - seg_index wraps to 0 and stage_word clears to 0 on the next cycle.
  - The assembled value, including the segment just written, is the completed word.
  - If word_valid = 0, or word_valid = 1 with word_ready = 1 in the same cycle: out_word <= completed word and word_valid <= 1, visible the cycle after the press.
  - If word_valid = 1 and word_ready = 0: the completed word is dropped, out_word is unchanged, overflow <= 1.
- Handshake: transfer occurs when word_valid & word_ready. word_valid falls the next cycle unless a completion coincides (see above). out_word is held stable while word_valid = 1.
- Segment states: FILL_0 .. FILL_{NUM_SEGS-1}, encoded by seg_index. The output side holds EMPTY or PENDING independently of the segment state.
- clear (synchronous, highest priority after reset):
  - seg_index <= 0, stage_word <= 0, overflow <= 0; a step in the same cycle is discarded.
  - out_word and word_valid are unaffected, so a pending word survives clear.
- Reset mid-fill discards all progress. Releasing reset while shift_in is held high does not generate a step.
- cs toggling mid-fill preserves seg_index and stage_word.

Test Plan:
- SW_WIDTH=4, NUM_SEGS=2, MSB_FIRST=0, cs=0, word_ready=0: press with dip=0x5, then press with dip=0xA -> out_word=0xA5, word_valid=1 one cycle after the second step; seg_index=0.
- Same sequence with MSB_FIRST=1 -> out_word=0x5A; after the first press stage_word=0x50 and seg_index=1.
- Bounce: shift_in toggles every 2 cycles for 10 cycles, then holds high -> exactly one step, fired DEBOUNCE_CYCLES+2 cycles after the final edge.
- cs=1 during one press of a 3-press sequence (NUM_SEGS=3, dips 1,2,3 with the second press under cs=1) -> that press is ignored; completion requires one extra press with cs=0.
- Word 0x12 pending with word_ready=0, second word 0x34 completes -> overflow=1, out_word stays 0x12. Assert word_ready on the completion cycle of a third word 0x56 -> out_word=0x56, word_valid stays 1.
- After one press (seg_index=1), assert clear -> seg_index=0, stage_word=0, overflow=0. Repeat and assert rst_n low mid-fill -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dip_word_loader.sv
// dip_word_loader
// Builds a NUM_SEGS-segment word from a SW_WIDTH-bit DIP switch. Each
// debounced press of the shift button loads one segment. Each completed word
// is offered to the Manchester encoder's transmit register over a valid/ready
// handshake. A word that completes while the previous one is still pending is
// dropped and recorded in a sticky overflow flag.
module dip_word_loader #(
    parameter int SW_WIDTH        = 4,
    parameter int NUM_SEGS        = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MSB_FIRST       = 0,
    localparam int W              = SW_WIDTH * NUM_SEGS,
    localparam int SEG_W          = $clog2(NUM_SEGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic [SW_WIDTH-1:0] dip_switch,
    input  logic                shift_in,
    input  logic                clear,
    input  logic                word_ready,
    output logic [W-1:0]        out_word,
    output logic                word_valid,
    output logic [W-1:0]        stage_word,
    output logic [SEG_W-1:0]    seg_index,
    output logic                overflow
);

    localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SEG_W-1:0] LAST_SEG    = SEG_W'(NUM_SEGS - 1);
    localparam logic [0:0]       OUT_EMPTY   = 1'b0;
    localparam logic [0:0]       OUT_PENDING = 1'b1;

    logic             sync_ff1;
    logic             sync_ff2;
    logic             db_level;
    logic [CNT_W-1:0] db_count;
    logic [1:0]       warm;
    logic             armed;
    logic             step;
    logic [0:0]       out_state;

    int               seg_k;
    logic [W-1:0]     filled_word;
    logic             accept;
    logic             last_seg;
    logic             complete;

    // Two-flop synchroniser for the asynchronous push-button.
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample their inputs from the same edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= shift_in;
            sync_ff2 <= sync_ff1;
        end
    end

    // Debounce the synchronised level and emit a one-cycle step on each
    // accepted rise. A rise is only reported once the button has been seen
    // released after reset, so holding it through reset release is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_count <= '0;
            warm     <= 2'b00;
            armed    <= 1'b0;
            step     <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            step <= 1'b0;
            // warm[1] means sync_ff2 now reflects a real sample of shift_in.
            if (warm[1] && !sync_ff2 && !db_level) begin
                armed <= 1'b1;
            end
            if (sync_ff2 != db_level) begin
                if (db_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= sync_ff2;
                    db_count <= '0;
                    step     <= sync_ff2 & armed;
                end else begin
                    db_count <= db_count + 1'b1;
                end
            end else begin
                // Input agrees with the accepted level: any bounce restarts.
                db_count <= '0;
            end
        end
    end

    // Staged word with the current segment replaced by the switch value.
    // NOTE: every variable is given a default before any conditional
    // assignment so this block stays purely combinational (no latch).
    always_comb begin
        seg_k       = (MSB_FIRST != 0) ? (NUM_SEGS - 1 - int'(seg_index))
                                       : int'(seg_index);
        filled_word = stage_word;
        for (int s = 0; s < NUM_SEGS; s++) begin
            if (s == seg_k) begin
                filled_word[s*SW_WIDTH +: SW_WIDTH] = dip_switch;
            end
        end
    end

    assign accept   = step & ~cs & ~clear;
    assign last_seg = (seg_index == LAST_SEG);
    assign complete = accept & last_seg;

    // Segment fill progress: FILL_0 .. FILL_{NUM_SEGS-1} encoded by seg_index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_index  <= '0;
            stage_word <= '0;
        end else if (clear) begin
            seg_index  <= '0;
            stage_word <= '0;
        end else if (accept) begin
            if (last_seg) begin
                seg_index  <= '0;
                stage_word <= '0;
            end else begin
                seg_index  <= seg_index + 1'b1;
                stage_word <= filled_word;
            end
        end
    end

    // Output side: EMPTY/PENDING handshake and sticky overflow. clear only
    // touches overflow; a pending word survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= OUT_EMPTY;
            out_word  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (complete) begin
                if (out_state == OUT_EMPTY || word_ready) begin
                    out_word  <= filled_word;
                    out_state <= OUT_PENDING;
                end
            end else if (out_state == OUT_PENDING && word_ready) begin
                out_state <= OUT_EMPTY;
            end

            if (clear) begin
                overflow <= 1'b0;
            end else if (complete && out_state == OUT_PENDING && !word_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    assign word_valid = (out_state == OUT_PENDING);

endmodule

// File: tb/tb_dip_word_loader.sv
// tb_dip_word_loader
// Directed bench for dip_word_loader. Three instances share the stimulus:
// 2 segments LSB-first, 2 segments MSB-first, and 3 segments LSB-first.
// Each scenario resets all three and then observes only the relevant one.
module tb_dip_word_loader;

    localparam int DEB = 4;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic [3:0]  dip_switch;
    logic        shift_in;
    logic        clear;
    logic        word_ready;

    logic [7:0]  out_word_a;
    logic        word_valid_a;
    logic [7:0]  stage_word_a;
    logic [0:0]  seg_index_a;
    logic        overflow_a;

    logic [7:0]  out_word_b;
    logic        word_valid_b;
    logic [7:0]  stage_word_b;
    logic [0:0]  seg_index_b;
    logic        overflow_b;

    logic [11:0] out_word_c;
    logic        word_valid_c;
    logic [11:0] stage_word_c;
    logic [1:0]  seg_index_c;
    logic        overflow_c;

    int tests_run;
    int tests_failed;

    dip_word_loader #(
        .SW_WIDTH(4), .NUM_SEGS(2), .DEBOUNCE_CYCLES(DEB), .MSB_FIRST(0)
    ) u_lsb (
        .clk(clk), .rst_n(rst_n), .cs(cs), .dip_switch(dip_switch),
        .shift_in(shift_in), .clear(clear), .word_ready(word_ready),
        .out_word(out_word_a), .word_valid(word_valid_a),
        .stage_word(stage_word_a), .seg_index(seg_index_a),
        .overflow(overflow_a)
    );

    dip_word_loader #(
        .SW_WIDTH(4), .NUM_SEGS(2), .DEBOUNCE_CYCLES(DEB), .MSB_FIRST(1)
    ) u_msb (
        .clk(clk), .rst_n(rst_n), .cs(cs), .dip_switch(dip_switch),
        .shift_in(shift_in), .clear(clear), .word_ready(word_ready),
        .out_word(out_word_b), .word_valid(word_valid_b),
        .stage_word(stage_word_b), .seg_index(seg_index_b),
        .overflow(overflow_b)
    );

    dip_word_loader #(
        .SW_WIDTH(4), .NUM_SEGS(3), .DEBOUNCE_CYCLES(DEB), .MSB_FIRST(0)
    ) u_seg3 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .dip_switch(dip_switch),
        .shift_in(shift_in), .clear(clear), .word_ready(word_ready),
        .out_word(out_word_c), .word_valid(word_valid_c),
        .stage_word(stage_word_c), .seg_index(seg_index_c),
        .overflow(overflow_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset all instances with every input idle, then let the synchroniser
    // warm up and arm before any press.
    task automatic apply_reset();
        cs         = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        shift_in   = 1'b0;
        dip_switch = 4'h0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Raise the button cleanly; return on the negedge after the accept edge
    // (step fires DEB+2 edges after the rise, the write lands one edge later).
    task automatic press_hold(input logic [3:0] dip, input logic ready_at_accept);
        dip_switch = dip;
        shift_in   = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        if (ready_at_accept) word_ready = 1'b1;
        @(negedge clk);
        if (ready_at_accept) word_ready = 1'b0;
    endtask

    // Release the button and wait until the debounced level is low again.
    task automatic release_btn();
        shift_in = 1'b0;
        repeat (DEB + 3) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] dip);
        press_hold(dip, 1'b0);
        release_btn();
    endtask

    task automatic test_reset();
        cs = 1'b0; clear = 1'b0; word_ready = 1'b0; shift_in = 1'b0; dip_switch = 4'hF;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_word_a !== 8'h00 || word_valid_a !== 1'b0 || overflow_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_a: out_word=%h valid=%b ovf=%b, expected 00/0/0",
                     out_word_a, word_valid_a, overflow_a);
        end
        tests_run++;
        if (stage_word_b !== 8'h00 || seg_index_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stage_b: stage=%h seg=%h, expected 00/0", stage_word_b, seg_index_b);
        end
        tests_run++;
        if (stage_word_c !== 12'h000 || seg_index_c !== 2'd0 || word_valid_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_c: stage=%h seg=%h valid=%b, expected 000/0/0",
                     stage_word_c, seg_index_c, word_valid_c);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_lsb_first();
        apply_reset();
        press(4'h5);
        tests_run++;
        if (stage_word_a !== 8'h05 || seg_index_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL lsb_first_press: stage=%h seg=%h, expected 05/1", stage_word_a, seg_index_a);
        end
        // Second press inline to check the exact cycle the word appears.
        dip_switch = 4'hA;
        shift_in   = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        tests_run++;
        if (word_valid_a !== 1'b0 || seg_index_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL lsb_step_cycle: valid=%b seg=%h, expected 0/1", word_valid_a, seg_index_a);
        end
        @(negedge clk);
        tests_run++;
        if (out_word_a !== 8'hA5 || word_valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL lsb_complete: out_word=%h valid=%b, expected A5/1", out_word_a, word_valid_a);
        end
        tests_run++;
        if (seg_index_a !== 1'b0 || stage_word_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL lsb_wrap: seg=%h stage=%h, expected 0/00", seg_index_a, stage_word_a);
        end
        release_btn();
    endtask

    task automatic test_msb_first();
        apply_reset();
        press(4'h5);
        tests_run++;
        if (stage_word_b !== 8'h50 || seg_index_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL msb_first_press: stage=%h seg=%h, expected 50/1", stage_word_b, seg_index_b);
        end
        press(4'hA);
        tests_run++;
        if (out_word_b !== 8'h5A || word_valid_b !== 1'b1 || seg_index_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL msb_complete: out_word=%h valid=%b seg=%h, expected 5A/1/0",
                     out_word_b, word_valid_b, seg_index_b);
        end
    endtask

    task automatic test_bounce();
        int first;
        apply_reset();
        dip_switch = 4'h7;
        for (int i = 0; i < 10; i++) begin
            shift_in = ((i % 4) >= 2);
            @(negedge clk);
        end
        tests_run++;
        if (seg_index_a !== 1'b0 || stage_word_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL bounce_no_step: seg=%h stage=%h, expected 0/00", seg_index_a, stage_word_a);
        end
        // Final edge: hold high from here.
        shift_in = 1'b1;
        first    = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (first == 0 && seg_index_a === 1'b1) first = k;
        end
        tests_run++;
        if (first != DEB + 3) begin
            tests_failed++;
            $display("FAIL bounce_latency: write seen at cycle %0d, expected %0d (0 = never)",
                     first, DEB + 3);
        end
        tests_run++;
        if (seg_index_a !== 1'b1 || stage_word_a !== 8'h07 || word_valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_single_step: seg=%h stage=%h valid=%b, expected 1/07/0",
                     seg_index_a, stage_word_a, word_valid_a);
        end
        release_btn();
    endtask

    task automatic test_reset_held();
        cs = 1'b0; clear = 1'b0; word_ready = 1'b0; dip_switch = 4'h9;
        shift_in = 1'b1;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (seg_index_a !== 1'b0 || stage_word_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_held_no_step: seg=%h stage=%h, expected 0/00", seg_index_a, stage_word_a);
        end
        shift_in = 1'b0;
        repeat (DEB + 5) @(negedge clk);
        press(4'h3);
        tests_run++;
        if (seg_index_a !== 1'b1 || stage_word_a !== 8'h03) begin
            tests_failed++;
            $display("FAIL reset_held_then_press: seg=%h stage=%h, expected 1/03", seg_index_a, stage_word_a);
        end
    endtask

    task automatic test_cs_ignore();
        apply_reset();
        press(4'h1);
        cs = 1'b1;
        press(4'h2);
        cs = 1'b0;
        tests_run++;
        if (stage_word_c !== 12'h001 || seg_index_c !== 2'd1) begin
            tests_failed++;
            $display("FAIL cs_ignored: stage=%h seg=%h, expected 001/1", stage_word_c, seg_index_c);
        end
        press(4'h3);
        tests_run++;
        if (stage_word_c !== 12'h031 || seg_index_c !== 2'd2 || word_valid_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL cs_third_press: stage=%h seg=%h valid=%b, expected 031/2/0",
                     stage_word_c, seg_index_c, word_valid_c);
        end
        press(4'h2);
        tests_run++;
        if (out_word_c !== 12'h231 || word_valid_c !== 1'b1 || seg_index_c !== 2'd0) begin
            tests_failed++;
            $display("FAIL cs_extra_press: out_word=%h valid=%b seg=%h, expected 231/1/0",
                     out_word_c, word_valid_c, seg_index_c);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        press(4'h2);
        press(4'h1);
        tests_run++;
        if (out_word_a !== 8'h12 || word_valid_a !== 1'b1 || overflow_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_first_word: out_word=%h valid=%b ovf=%b, expected 12/1/0",
                     out_word_a, word_valid_a, overflow_a);
        end
        press(4'h4);
        press(4'h3);
        tests_run++;
        if (out_word_a !== 8'h12 || word_valid_a !== 1'b1 || overflow_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_dropped: out_word=%h valid=%b ovf=%b, expected 12/1/1",
                     out_word_a, word_valid_a, overflow_a);
        end
        press(4'h6);
        press_hold(4'h5, 1'b1);
        tests_run++;
        if (out_word_a !== 8'h56 || word_valid_a !== 1'b1 || overflow_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_back_to_back: out_word=%h valid=%b ovf=%b, expected 56/1/1",
                     out_word_a, word_valid_a, overflow_a);
        end
        release_btn();
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        tests_run++;
        if (word_valid_a !== 1'b0 || out_word_a !== 8'h56) begin
            tests_failed++;
            $display("FAIL handshake_drop: valid=%b out_word=%h, expected 0/56", word_valid_a, out_word_a);
        end
    endtask

    task automatic test_clear_and_async_reset();
        apply_reset();
        press(4'h5);
        press(4'hA);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        tests_run++;
        if (seg_index_a !== 1'b1 || overflow_a !== 1'b1 || stage_word_a !== 8'h03) begin
            tests_failed++;
            $display("FAIL clear_setup: seg=%h ovf=%b stage=%h, expected 1/1/03",
                     seg_index_a, overflow_a, stage_word_a);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        tests_run++;
        if (seg_index_a !== 1'b0 || stage_word_a !== 8'h00 || overflow_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_progress: seg=%h stage=%h ovf=%b, expected 0/00/0",
                     seg_index_a, stage_word_a, overflow_a);
        end
        tests_run++;
        if (word_valid_a !== 1'b1 || out_word_a !== 8'hA5) begin
            tests_failed++;
            $display("FAIL clear_keeps_word: valid=%b out_word=%h, expected 1/A5", word_valid_a, out_word_a);
        end
        // Step coinciding with clear must be discarded.
        dip_switch = 4'h9;
        shift_in   = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        tests_run++;
        if (seg_index_a !== 1'b0 || stage_word_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL clear_with_step: seg=%h stage=%h, expected 0/00", seg_index_a, stage_word_a);
        end
        release_btn();
        press(4'h4);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (seg_index_a !== 1'b0 || stage_word_a !== 8'h00 || out_word_a !== 8'h00 ||
            word_valid_a !== 1'b0 || overflow_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: seg=%h stage=%h out=%h valid=%b ovf=%b, expected all 0",
                     seg_index_a, stage_word_a, out_word_a, word_valid_a, overflow_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        cs           = 1'b0;
        clear        = 1'b0;
        word_ready   = 1'b0;
        shift_in     = 1'b0;
        dip_switch   = 4'h0;
        @(negedge clk);
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_bounce();
        test_reset_held();
        test_cs_ignore();
        test_overflow();
        test_clear_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
